// File: rtl/serial_frame_tx.sv
// serial_frame_tx: sends one framed word on a single serial line.
// A frame is a start bit (0), an 8-bit header {port_addr, data_len} sent
// MSB-first, then data_len payload bits from data_in[data_len-1] down to
// data_in[0]. The line idles at 1. All outputs depend only on state and
// captured registers, so start has no combinational path to any output.
module serial_frame_tx (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  port_addr,
  input  logic [5:0]  data_len,
  input  logic [63:0] data_in,
  output logic        serout,
  output logic        serout_active,
  output logic        ready,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, START, HDR, PAY} state_t;

  state_t      state, state_n;
  logic [5:0]  cnt, cnt_n;
  logic [1:0]  port_q;
  logic [5:0]  len_q;
  logic [63:0] data_q;
  logic        cap;
  logic [7:0]  hdr;

  assign hdr = {port_q, len_q};

  // State, bit counter and frame capture registers; reset aborts any frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      port_q <= '0;
      len_q  <= '0;
      data_q <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (cap) begin
        port_q <= port_addr;
        len_q  <= data_len;
        data_q <= data_in;
      end
    end
  end

  // Next state and bit selection. The counter counts down to 0 in HDR and
  // PAY; done is raised on whichever cycle carries the frame's last bit.
  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    cap           = 1'b0;
    serout        = 1'b1;
    serout_active = 1'b0;
    ready         = 1'b0;
    done          = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          cap     = 1'b1;
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        serout        = 1'b0;
        serout_active = 1'b1;
        state_n       = HDR;
        cnt_n         = 6'd7;
      end
      HDR: begin
        serout        = hdr[cnt[2:0]];
        serout_active = 1'b1;
        if (cnt == 6'd0) begin
          if (len_q != 6'd0) begin
            state_n = PAY;
            cnt_n   = len_q - 6'd1;
          end else begin
            state_n = IDLE;
            done    = 1'b1;
          end
        end else begin
          cnt_n = cnt - 6'd1;
        end
      end
      PAY: begin
        serout        = data_q[cnt];
        serout_active = 1'b1;
        if (cnt == 6'd0) begin
          state_n = IDLE;
          done    = 1'b1;
        end else begin
          cnt_n = cnt - 6'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx. A queue-based reference model holds the bits
// still to be sent for the frame in flight; every cycle the DUT outputs are
// compared against the head of that queue. Directed cases also compare the
// recorded serial trace against literal bit strings.
module tb_serial_frame_tx;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [1:0]  port_addr;
  logic [5:0]  data_len;
  logic [63:0] data_in;
  logic        serout, serout_active, ready, done;

  int checks = 0;
  int errors = 0;

  logic        mdl_q[$];
  bit          chk_on = 1'b0;
  logic [63:0] trace = '0;
  int          done_cnt = 0;

  serial_frame_tx dut (
    .clk(clk), .rst(rst), .start(start), .port_addr(port_addr),
    .data_len(data_len), .data_in(data_in), .serout(serout),
    .serout_active(serout_active), .ready(ready), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: an accepted frame becomes a list of line bits; one bit
  // is consumed per cycle, and a new request is only taken when the list is
  // empty (the idle cycle).
  always @(posedge clk) begin
    if (rst) begin
      mdl_q.delete();
    end else if (mdl_q.size() == 0) begin
      if (start) begin
        logic [7:0] h;
        h = {port_addr, data_len};
        mdl_q.push_back(1'b0);
        for (int i = 7; i >= 0; i--) mdl_q.push_back(h[i]);
        for (int i = int'(data_len) - 1; i >= 0; i--) mdl_q.push_back(data_in[i]);
      end
    end else begin
      void'(mdl_q.pop_front());
    end
  end

  // Compare against the model mid-cycle, and record the line for literal checks.
  always @(negedge clk) begin
    trace = {trace[62:0], serout};
    if (done === 1'b1) done_cnt++;
    if (chk_on) begin
      chk("serout", serout, (mdl_q.size() > 0) ? mdl_q[0] : 1'b1);
      chk("active", serout_active, mdl_q.size() > 0);
      chk("ready", ready, mdl_q.size() == 0);
      chk("done", done, mdl_q.size() == 1);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic setin(input logic s, input logic [1:0] p, input logic [5:0] l, input logic [63:0] d);
    start = s; port_addr = p; data_len = l; data_in = d;
  endtask

  int d0;

  initial begin
    rst = 1'b1;
    setin(1'b0, 2'b00, 6'd0, 64'd0);
    cyc(1);
    chk_on = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(2);

    // Documented example: port 2, four payload bits 1011.
    d0 = done_cnt;
    setin(1'b1, 2'b10, 6'd4, 64'hB);
    cyc(1);
    setin(1'b0, 2'b11, 6'd9, 64'h0);
    cyc(14);
    chk("ex1_trace", {50'd0, trace[13:0]}, {50'd0, 14'b01000010010111});
    chk("ex1_done", done_cnt - d0, 1);
    cyc(2);

    // Zero-length frame: header only.
    d0 = done_cnt;
    setin(1'b1, 2'b01, 6'd0, 64'hFFFF);
    cyc(1);
    start = 1'b0;
    cyc(10);
    chk("len0_trace", {54'd0, trace[9:0]}, {54'd0, 10'b0010000001});
    chk("len0_done", done_cnt - d0, 1);
    cyc(2);

    // Maximum length, all ones: bit 63 is never sent.
    d0 = done_cnt;
    setin(1'b1, 2'b11, 6'd63, 64'hFFFF_FFFF_FFFF_FFFF);
    cyc(1);
    start = 1'b0;
    cyc(73);
    chk("len63_payload", {1'b0, trace[63:1]}, {1'b0, 63'h7FFF_FFFF_FFFF_FFFF});
    chk("len63_done", done_cnt - d0, 1);
    cyc(2);

    // Maximum length with bit 63 differing from the rest.
    setin(1'b1, 2'b00, 6'd63, 64'h8000_0000_0000_0000);
    cyc(1);
    start = 1'b0;
    cyc(75);

    // A second request during the header is ignored.
    d0 = done_cnt;
    setin(1'b1, 2'b10, 6'd3, 64'h5);
    cyc(1);
    setin(1'b0, 2'b01, 6'd7, 64'h7F);
    cyc(3);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(20);
    chk("ignore_done", done_cnt - d0, 1);

    // Reset on the fourth header bit aborts the frame without done.
    d0 = done_cnt;
    setin(1'b1, 2'b11, 6'd5, 64'h15);
    cyc(1);
    start = 1'b0;
    cyc(4);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("abort_idle", {62'd0, serout, ready}, 64'd3);
    cyc(3);
    chk("abort_done", done_cnt - d0, 0);
    setin(1'b1, 2'b01, 6'd5, 64'h16);
    cyc(1);
    start = 1'b0;
    cyc(16);

    // Held start: two frames with a single idle bit between them.
    d0 = done_cnt;
    setin(1'b1, 2'b00, 6'd2, 64'h2);
    cyc(13);
    start = 1'b0;
    cyc(12);
    chk("b2b_trace", {40'd0, trace[23:0]}, {40'd0, 24'b000000010101_000000010101});
    chk("b2b_done", done_cnt - d0, 2);
    cyc(2);

    // Random traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      setin(($urandom_range(3) == 0), 2'($urandom), 6'($urandom), {$urandom, $urandom});
      rst = ($urandom_range(199) == 0);
      cyc(1);
    end
    setin(1'b0, 2'b00, 6'd0, 64'd0);
    rst = 1'b0;
    cyc(80);

    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_frame_tx.md
SERIAL_FRAME_TX -- requirements
Module: serial_frame_tx

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  in  1  single clock; all state changes on posedge clk.
REQ-003 rst  in  1  synchronous, active-high reset; sampled on posedge clk.
REQ-004 start  in  1  frame request; accepted only when ready=1 at the clock edge.
REQ-005 port_addr  in  2  destination port; captured on accept.
REQ-006 data_len  in  6  payload bit count, 0..63; captured on accept.
REQ-007 data_in  in  64  payload; bits data_in[data_len-1:0] are sent; captured on accept.
REQ-008 serout  out  1  serial line; idle level 1.
REQ-009 serout_active  out  1  high while serout carries a start, header or payload bit.
REQ-010 ready  out  1  high in IDLE only.
REQ-011 done  out  1  one-cycle pulse coincident with the last bit of a frame.

Function
REQ-012 Frame format SHALL be: one start bit (0), then 8 header bits {port_addr, data_len} MSB-first, then data_len payload bits from data_in[data_len-1] down to data_in[0].
REQ-013 The FSM SHALL have states IDLE, START, HDR and PAY, each emitting one bit per clock.
REQ-014 IDLE: serout=1, ready=1, serout_active=0; on start=1 capture all inputs, next state START.
REQ-015 START: serout=0 for exactly one cycle, next state HDR with the header counter at 7.
REQ-016 HDR: serout = header bit selected by the counter; decrement each cycle; after bit 0 go to PAY if captured len>0, else IDLE.
REQ-017 PAY: serout = captured data bit at index counter, starting from len-1; after bit 0 go to IDLE.
REQ-018 done SHALL be 1 during the final bit cycle: the last HDR cycle if len=0, otherwise the last PAY cycle; 0 in all other cycles.
REQ-019 serout_active SHALL be 1 in START, HDR and PAY, and 0 in IDLE.
REQ-020 Latency: start accepted at edge T puts the start bit on serout from T to T+1; a frame occupies exactly 9+len cycles.
REQ-021 start while ready=0 SHALL be ignored and not queued; input changes after accept SHALL NOT affect the frame in progress.
REQ-022 Back-to-back: start held high yields exactly one idle (1) bit between consecutive frames; this is the minimum gap.
REQ-023 Counters SHALL be 6 bits wide with no wrap-around; len=63 sends data_in[62:0] only, and bit 63 is never sent.
REQ-024 serout, serout_active, ready and done SHALL be glitch-free registered or decoded-from-state outputs, with no combinational path from start.

Reset
REQ-025 On rst=1 at an edge: state IDLE, counters 0, captured registers 0; next cycle serout=1, ready=1, serout_active=0, done=0.
REQ-026 Reset during any state SHALL abort the frame immediately, with no done pulse; rst has priority over start in the same cycle.

Verification
REQ-027 port=2'b10, len=4, data_in[3:0]=4'b1011, start pulse -> serout 0,1,0,0,0,0,1,0,0,1,0,1,1 then 1; done only on the 13th bit; ready returns on the next cycle.
REQ-028 port=2'b01, len=0 -> serout 0,0,1,0,0,0,0,0,0 (9 bits); done on the 9th bit; no payload cycles.
REQ-029 len=63, data_in=64'hFFFF_FFFF_FFFF_FFFF -> 72 active cycles; the payload is 63 ones; done on cycle 72.
REQ-030 Start pulsed again during HDR with different port/len -> ignored; current frame unchanged; no second frame starts.
REQ-031 rst asserted on the 4th header bit -> next cycle serout=1, ready=1, done never pulses; a new start then yields a full, correct frame.
REQ-032 start held high for two frames (len=2, data 2'b10) -> frame, exactly one 1-bit gap, then the second frame; done pulses once per frame.
